// File: rtl/mult_feeder.sv
// Pairs a matrix-element stream with a vector-element stream for a multiplier pipe.
// Each side has its own FIFO. A pair issues whenever both FIFOs hold data and downstream is not stalled.
module mult_feeder #(
   parameter int ROW_WIDTH = 10,
   parameter int DEPTH_LOG = 4,
   parameter int AF_THRESH = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 m_push_in,
   input  logic [ROW_WIDTH-1:0] m_row_in,
   input  logic [65:0]          m_val_in,
   output logic                 m_almost_full,
   input  logic                 v_push_in,
   input  logic [65:0]          v_val_in,
   output logic                 v_almost_full,
   input  logic                 stall_in,
   output logic                 push_out,
   output logic [ROW_WIDTH-1:0] row_out,
   output logic [65:0]          v0_out,
   output logic [65:0]          v1_out,
   output logic                 overflow,
   output logic [31:0]          pair_count
);

   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam logic [DEPTH_LOG:0]   FULL_CNT = {1'b1, {DEPTH_LOG{1'b0}}};
   localparam logic [DEPTH_LOG:0]   ZERO_CNT = {(DEPTH_LOG+1){1'b0}};
   localparam logic [DEPTH_LOG:0]   ONE_CNT  = {{DEPTH_LOG{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG-1:0] ONE_PTR  = {{(DEPTH_LOG-1){1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG:0]   AF_CNT   = (DEPTH_LOG+1)'(AF_THRESH);

   logic [ROW_WIDTH-1:0] m_row_mem [DEPTH];
   logic [65:0]          m_val_mem [DEPTH];
   logic [65:0]          v_val_mem [DEPTH];

   logic [DEPTH_LOG-1:0] m_wptr_q, m_wptr_d, m_rptr_q, m_rptr_d;
   logic [DEPTH_LOG-1:0] v_wptr_q, v_wptr_d, v_rptr_q, v_rptr_d;
   logic [DEPTH_LOG:0]   m_cnt_q, m_cnt_d, v_cnt_q, v_cnt_d;
   logic                 m_af_q, m_af_d, v_af_q, v_af_d;
   logic                 push_out_q, push_out_d;
   logic [ROW_WIDTH-1:0] row_out_q, row_out_d;
   logic [65:0]          v0_out_q, v0_out_d, v1_out_q, v1_out_d;
   logic                 overflow_q, overflow_d;
   logic [31:0]          pair_count_q, pair_count_d;

   logic issue_s, m_accept_s, v_accept_s;

   // Issue and push acceptance; a full queue takes a push only while it is popping.
   always_comb begin
      issue_s    = 1'b0;
      m_accept_s = 1'b0;
      v_accept_s = 1'b0;
      if (rst) begin
         issue_s    = 1'b0;
         m_accept_s = 1'b0;
         v_accept_s = 1'b0;
      end else begin
         issue_s    = (m_cnt_q != ZERO_CNT) && (v_cnt_q != ZERO_CNT) && !stall_in;
         m_accept_s = m_push_in && ((m_cnt_q != FULL_CNT) || issue_s);
         v_accept_s = v_push_in && ((v_cnt_q != FULL_CNT) || issue_s);
      end
   end

   // Next-state for pointers, counts, flags and the output pair register.
   always_comb begin
      m_wptr_d     = m_wptr_q;
      m_rptr_d     = m_rptr_q;
      v_wptr_d     = v_wptr_q;
      v_rptr_d     = v_rptr_q;
      m_cnt_d      = m_cnt_q;
      v_cnt_d      = v_cnt_q;
      push_out_d   = issue_s;
      row_out_d    = row_out_q;
      v0_out_d     = v0_out_q;
      v1_out_d     = v1_out_q;
      pair_count_d = pair_count_q;
      overflow_d   = overflow_q;

      if (m_accept_s) begin
         m_wptr_d = m_wptr_q + ONE_PTR;
      end else begin
         m_wptr_d = m_wptr_q;
      end
      if (v_accept_s) begin
         v_wptr_d = v_wptr_q + ONE_PTR;
      end else begin
         v_wptr_d = v_wptr_q;
      end

      if (issue_s) begin
         m_rptr_d     = m_rptr_q + ONE_PTR;
         v_rptr_d     = v_rptr_q + ONE_PTR;
         row_out_d    = m_row_mem[m_rptr_q];
         v0_out_d     = m_val_mem[m_rptr_q];
         v1_out_d     = v_val_mem[v_rptr_q];
         pair_count_d = pair_count_q + 32'd1;
      end else begin
         m_rptr_d     = m_rptr_q;
         v_rptr_d     = v_rptr_q;
         pair_count_d = pair_count_q;
      end

      case ({m_accept_s, issue_s})
         2'b10:   m_cnt_d = m_cnt_q + ONE_CNT;
         2'b01:   m_cnt_d = m_cnt_q - ONE_CNT;
         default: m_cnt_d = m_cnt_q;
      endcase
      case ({v_accept_s, issue_s})
         2'b10:   v_cnt_d = v_cnt_q + ONE_CNT;
         2'b01:   v_cnt_d = v_cnt_q - ONE_CNT;
         default: v_cnt_d = v_cnt_q;
      endcase

      if ((m_push_in && !m_accept_s) || (v_push_in && !v_accept_s)) begin
         overflow_d = !rst;
      end else begin
         overflow_d = overflow_q;
      end

      m_af_d = (m_cnt_d >= AF_CNT);
      v_af_d = (v_cnt_d >= AF_CNT);
   end

   // Queue storage; payload needs no reset since pointers gate every read.
   always_ff @(posedge clk) begin
      if (m_accept_s) begin
         m_row_mem[m_wptr_q] <= m_row_in;
         m_val_mem[m_wptr_q] <= m_val_in;
      end
      if (v_accept_s) begin
         v_val_mem[v_wptr_q] <= v_val_in;
      end
   end

   // Control and output state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_wptr_q     <= {DEPTH_LOG{1'b0}};
         m_rptr_q     <= {DEPTH_LOG{1'b0}};
         v_wptr_q     <= {DEPTH_LOG{1'b0}};
         v_rptr_q     <= {DEPTH_LOG{1'b0}};
         m_cnt_q      <= ZERO_CNT;
         v_cnt_q      <= ZERO_CNT;
         m_af_q       <= 1'b0;
         v_af_q       <= 1'b0;
         push_out_q   <= 1'b0;
         row_out_q    <= {ROW_WIDTH{1'b0}};
         v0_out_q     <= 66'd0;
         v1_out_q     <= 66'd0;
         overflow_q   <= 1'b0;
         pair_count_q <= 32'd0;
      end else begin
         m_wptr_q     <= m_wptr_d;
         m_rptr_q     <= m_rptr_d;
         v_wptr_q     <= v_wptr_d;
         v_rptr_q     <= v_rptr_d;
         m_cnt_q      <= m_cnt_d;
         v_cnt_q      <= v_cnt_d;
         m_af_q       <= m_af_d;
         v_af_q       <= v_af_d;
         push_out_q   <= push_out_d;
         row_out_q    <= row_out_d;
         v0_out_q     <= v0_out_d;
         v1_out_q     <= v1_out_d;
         overflow_q   <= overflow_d;
         pair_count_q <= pair_count_d;
      end
   end

   assign m_almost_full = m_af_q;
   assign v_almost_full = v_af_q;
   assign push_out      = push_out_q;
   assign row_out       = row_out_q;
   assign v0_out        = v0_out_q;
   assign v1_out        = v1_out_q;
   assign overflow      = overflow_q;
   assign pair_count    = pair_count_q;

endmodule

// File: tb/tb_mult_feeder.sv
// Directed-plus-random bench for mult_feeder.
// It compares the DUT against a queue-based reference model that is updated every cycle.
module tb_mult_feeder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m_push_in = 1'b0;
   logic [9:0]  m_row_in = 10'd0;
   logic [65:0] m_val_in = 66'd0;
   logic        m_almost_full;
   logic        v_push_in = 1'b0;
   logic [65:0] v_val_in = 66'd0;
   logic        v_almost_full;
   logic        stall_in = 1'b0;
   logic        push_out;
   logic [9:0]  row_out;
   logic [65:0] v0_out, v1_out;
   logic        overflow;
   logic [31:0] pair_count;

   mult_feeder dut (
      .clk(clk), .rst(rst),
      .m_push_in(m_push_in), .m_row_in(m_row_in), .m_val_in(m_val_in),
      .m_almost_full(m_almost_full),
      .v_push_in(v_push_in), .v_val_in(v_val_in), .v_almost_full(v_almost_full),
      .stall_in(stall_in),
      .push_out(push_out), .row_out(row_out), .v0_out(v0_out), .v1_out(v1_out),
      .overflow(overflow), .pair_count(pair_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  row;
      logic [65:0] val;
   } m_ent_t;

   m_ent_t      mq[$];
   logic [65:0] vq[$];
   logic        e_push = 1'b0, e_ovf = 1'b0, e_maf = 1'b0, e_vaf = 1'b0;
   logic [9:0]  e_row = 10'd0;
   logic [65:0] e_v0 = 66'd0, e_v1 = 66'd0;
   logic [31:0] e_cnt = 32'd0;
   int          passed = 0, total = 0;
   int          pulses = 0;

   function automatic logic [65:0] rand66();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[65:0];
   endfunction

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Applies one cycle of inputs, advances the reference model, then compares after the edge.
   task automatic step(input logic mp, input logic [9:0] mr, input logic [65:0] mv,
                       input logic vp, input logic [65:0] vv, input logic st, input logic r);
      logic iss;
      m_push_in = mp; m_row_in = mr; m_val_in = mv;
      v_push_in = vp; v_val_in = vv; stall_in = st; rst = r;
      if (r) begin
         mq.delete(); vq.delete();
         e_push = 1'b0; e_row = 10'd0; e_v0 = 66'd0; e_v1 = 66'd0;
         e_cnt = 32'd0; e_ovf = 1'b0;
      end else begin
         iss = (mq.size() > 0) && (vq.size() > 0) && !st;
         e_push = iss;
         if (iss) begin
            e_row = mq[0].row; e_v0 = mq[0].val; e_v1 = vq[0];
            void'(mq.pop_front()); void'(vq.pop_front());
            e_cnt = e_cnt + 32'd1;
         end
         if (mp) begin
            if (mq.size() < 16) mq.push_back('{mr, mv});
            else e_ovf = 1'b1;
         end
         if (vp) begin
            if (vq.size() < 16) vq.push_back(vv);
            else e_ovf = 1'b1;
         end
      end
      e_maf = (mq.size() >= 12);
      e_vaf = (vq.size() >= 12);
      @(posedge clk);
      #1;
      if (e_push) pulses++;
      chk("push_out", {65'd0, push_out}, {65'd0, e_push});
      chk("row_out", {56'd0, row_out}, {56'd0, e_row});
      chk("v0_out", v0_out, e_v0);
      chk("v1_out", v1_out, e_v1);
      chk("pair_count", {34'd0, pair_count}, {34'd0, e_cnt});
      chk("overflow", {65'd0, overflow}, {65'd0, e_ovf});
      chk("m_almost_full", {65'd0, m_almost_full}, {65'd0, e_maf});
      chk("v_almost_full", {65'd0, v_almost_full}, {65'd0, e_vaf});
   endtask

   task automatic idle(input logic st);
      step(1'b0, 10'd0, 66'd0, 1'b0, 66'd0, st, 1'b0);
   endtask

   initial begin
      // Reset
      step(1'b1, 10'd3, rand66(), 1'b1, rand66(), 1'b0, 1'b1);
      step(1'b0, 10'd0, 66'd0, 1'b0, 66'd0, 1'b0, 1'b1);

      // Single pair: both pushed together, pulse appears after the second edge
      step(1'b1, 10'd5, 66'h1, 1'b1, 66'h2, 1'b0, 1'b0);
      chk("single_not_early", {65'd0, push_out}, 66'd0);
      idle(1'b0);
      chk("single_pulse", {65'd0, push_out}, 66'd1);
      chk("single_row", {56'd0, row_out}, 66'd5);
      idle(1'b0);
      chk("single_count", {34'd0, pair_count}, 66'd1);

      // Streaming 20 pairs
      pulses = 0;
      for (int i = 0; i < 20; i++) step(1'b1, 10'($urandom_range(0, 1023)), rand66(),
                                        1'b1, rand66(), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) idle(1'b0);
      chk("stream_pulses", 66'(pulses), 66'd20);
      chk("stream_count", {34'd0, pair_count}, 66'd21);

      // Backpressure to almost-full, then release
      for (int i = 0; i < 12; i++) step(1'b1, 10'($urandom_range(0, 1023)), rand66(),
                                        1'b1, rand66(), 1'b1, 1'b0);
      chk("af_m_high", {65'd0, m_almost_full}, 66'd1);
      chk("af_v_high", {65'd0, v_almost_full}, 66'd1);
      pulses = 0;
      for (int i = 0; i < 14; i++) idle(1'b0);
      chk("af_pulses", 66'(pulses), 66'd12);
      chk("af_m_low", {65'd0, m_almost_full}, 66'd0);

      // Overflow: 17 M with no V, then drain with 16 V
      for (int i = 0; i < 17; i++) step(1'b1, 10'(i + 100), rand66(), 1'b0, 66'd0, 1'b0, 1'b0);
      chk("ovf_set", {65'd0, overflow}, 66'd1);
      pulses = 0;
      for (int i = 0; i < 16; i++) step(1'b0, 10'd0, 66'd0, 1'b1, rand66(), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) idle(1'b0);
      chk("ovf_pairs", 66'(pulses), 66'd16);
      chk("ovf_last_row", {56'd0, row_out}, 66'd115);

      // Full push-with-pop needs a clean overflow flag
      step(1'b0, 10'd0, 66'd0, 1'b0, 66'd0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b1, 10'($urandom_range(0, 1023)), rand66(),
                                        1'b0, 66'd0, 1'b0, 1'b0);
      step(1'b0, 10'd0, 66'd0, 1'b1, rand66(), 1'b1, 1'b0);
      step(1'b1, 10'd77, rand66(), 1'b0, 66'd0, 1'b0, 1'b0);
      chk("full_pushpop_ovf", {65'd0, overflow}, 66'd0);
      chk("full_pushpop_mq", 66'(mq.size()), 66'd16);
      step(1'b1, 10'd78, rand66(), 1'b0, 66'd0, 1'b0, 1'b0);
      chk("full_no_pop_ovf", {65'd0, overflow}, 66'd1);

      // Mid-operation reset with 8 entries queued on each side
      step(1'b0, 10'd0, 66'd0, 1'b0, 66'd0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, 10'($urandom_range(0, 1023)), rand66(),
                                       1'b1, rand66(), 1'b1, 1'b0);
      step(1'b1, 10'd9, rand66(), 1'b1, rand66(), 1'b0, 1'b1);
      chk("midrst_push", {65'd0, push_out}, 66'd0);
      chk("midrst_count", {34'd0, pair_count}, 66'd0);
      pulses = 0;
      for (int i = 0; i < 4; i++) idle(1'b0);
      chk("midrst_no_stale", 66'(pulses), 66'd0);

      // Random traffic
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 3) != 0), 10'($urandom_range(0, 1023)), rand66(),
              1'($urandom_range(0, 2) != 0), rand66(), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 199) == 0));
      for (int i = 0; i < 20; i++) idle(1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
